// File: rtl/hand_zone_pixel_streamer.sv
// Camera front end for the hand-signal zone detector.
// Assembles RGB444 pixels from a vsync/href framed 8-bit byte bus. It tracks x/y and the
// zone index incrementally, so no divider is needed. It also flags malformed lines and
// frames that end early.
// Optional build macro HAND_TEST_PATTERN_EN adds a test_mode input. When test_mode is set,
// the camera data is replaced by a red/blue pattern that alternates by zone column.
module hand_zone_pixel_streamer #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned NX         = 8,
  parameter int unsigned NY         = 6,
  parameter int unsigned ZONES      = NX * NY,
  parameter int unsigned IMG_WB     = $clog2(IMG_WIDTH),
  parameter int unsigned IMG_HB     = $clog2(IMG_HEIGHT)
) (
  input  logic                       pclk,
  input  logic                       rst_n,
  input  logic                       vsync,
  input  logic                       href,
  input  logic [7:0]                 cam_d,
`ifdef HAND_TEST_PATTERN_EN
  input  logic                       test_mode,
`endif
  output logic                       pix_valid,
  output logic [IMG_WB-1:0]          x_pixel,
  output logic [IMG_HB-1:0]          y_pixel,
  output logic [$clog2(ZONES)-1:0]   zone_id,
  output logic [11:0]                pixel_COLOR,
  output logic                       frame_start,
  output logic                       frame_done,
  output logic                       frame_short,
  output logic                       line_err
);

  localparam int unsigned ZW  = IMG_WIDTH / NX;
  localparam int unsigned ZH  = IMG_HEIGHT / NY;
  localparam int unsigned ZB  = $clog2(ZONES);
  // One spare bit so over-long lines and the final line count stay representable
  localparam int unsigned XCB = IMG_WB + 1;
  localparam int unsigned YCB = IMG_HB + 1;
  localparam int unsigned ZWB = (ZW > 1) ? $clog2(ZW) : 1;
  localparam int unsigned ZHB = (ZH > 1) ? $clog2(ZH) : 1;
  localparam int unsigned ZCB = (NX > 1) ? $clog2(NX) : 1;
  localparam int unsigned ZRB = (NY > 1) ? $clog2(NY) : 1;

  localparam logic [XCB-1:0] XEnd     = XCB'(IMG_WIDTH);
  localparam logic [YCB-1:0] YEnd     = YCB'(IMG_HEIGHT);
  localparam logic [ZWB-1:0] ZwLast   = ZWB'(ZW - 1);
  localparam logic [ZHB-1:0] ZhLast   = ZHB'(ZH - 1);
  localparam logic [ZCB-1:0] ZcolLast = ZCB'(NX - 1);
  localparam logic [ZRB-1:0] ZrowLast = ZRB'(NY - 1);
  localparam logic [ZB-1:0]  NxZ      = ZB'(NX);

  typedef enum logic [1:0] {StBlank, StWaitLine, StLine} state_e;

  state_e            state_q, state_d;
  logic              vsync_q, href_q;
  logic              phase_q, phase_d;
  logic [3:0]        r_q, r_d;
  logic [XCB-1:0]    x_q, x_d;
  logic [YCB-1:0]    y_q, y_d, y_inc;
  logic [ZWB-1:0]    zx_q, zx_d;
  logic [ZCB-1:0]    zcol_q, zcol_d;
  logic [ZHB-1:0]    zy_q, zy_d;
  logic [ZRB-1:0]    zrow_q, zrow_d;

  logic              pix_valid_q, pix_valid_d;
  logic [IMG_WB-1:0] x_pixel_q, x_pixel_d;
  logic [IMG_HB-1:0] y_pixel_q, y_pixel_d;
  logic [ZB-1:0]     zone_id_q, zone_id_d;
  logic [11:0]       color_q, color_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_short_q, frame_short_d;
  logic              line_err_q, line_err_d;

  logic              vsync_fall, vsync_rise, href_fall;
  logic [7:0]        byte_w;

  assign vsync_fall = vsync_q & ~vsync;
  assign vsync_rise = ~vsync_q & vsync;
  assign href_fall  = href_q & ~href;

`ifdef HAND_TEST_PATTERN_EN
  logic tm_q, tm_d;

  // Mode is only picked up while blanking so a frame never mixes sources
  assign tm_d = (state_q == StBlank) ? test_mode : tm_q;

  // Test-mode register
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) tm_q <= 1'b0;
    else        tm_q <= tm_d;
  end

  // Even zone column -> F00, odd -> 00F, split across the two byte phases
  always_comb begin
    byte_w = cam_d;
    if (tm_q) begin
      if (!phase_q) byte_w = zcol_q[0] ? 8'h00 : 8'h0F;
      else          byte_w = zcol_q[0] ? 8'h0F : 8'h00;
    end
  end
`else
  assign byte_w = cam_d;
`endif

  // Frame/line FSM, byte assembly, coordinate and zone counters
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    r_d           = r_q;
    x_d           = x_q;
    y_d           = y_q;
    y_inc         = y_q + 1'b1;
    zx_d          = zx_q;
    zcol_d        = zcol_q;
    zy_d          = zy_q;
    zrow_d        = zrow_q;
    pix_valid_d   = 1'b0;
    x_pixel_d     = x_pixel_q;
    y_pixel_d     = y_pixel_q;
    zone_id_d     = zone_id_q;
    color_d       = color_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    frame_short_d = 1'b0;
    line_err_d    = 1'b0;

    unique case (state_q)
      StBlank: begin
        phase_d = 1'b0;
        x_d     = '0;
        y_d     = '0;
        zx_d    = '0;
        zcol_d  = '0;
        zy_d    = '0;
        zrow_d  = '0;
        if (vsync_fall) state_d = StWaitLine;
      end

      StWaitLine, StLine: begin
        if (href_fall && (state_q == StLine)) begin
          // Line check comes first; a coincident vsync rise only picks the done flavour
          line_err_d = phase_q | (x_q != XEnd);
          phase_d    = 1'b0;
          x_d        = '0;
          zx_d       = '0;
          zcol_d     = '0;
          y_d        = y_inc;
          if (zy_q == ZhLast) begin
            zy_d = '0;
            if (zrow_q != ZrowLast) zrow_d = zrow_q + 1'b1;
          end else begin
            zy_d = zy_q + 1'b1;
          end
          if (y_inc == YEnd) begin
            frame_done_d = 1'b1;
            state_d      = StBlank;
          end else if (vsync_rise) begin
            frame_done_d  = 1'b1;
            frame_short_d = 1'b1;
            state_d       = StBlank;
          end else begin
            state_d = StWaitLine;
          end
        end else if (vsync_rise) begin
          frame_done_d  = 1'b1;
          frame_short_d = 1'b1;
          state_d       = StBlank;
        end else if (href) begin
          state_d = StLine;
          if (!phase_q) begin
            r_d     = byte_w[3:0];
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if ((x_q < XEnd) && (y_q < YEnd)) begin
              pix_valid_d   = 1'b1;
              x_pixel_d     = x_q[IMG_WB-1:0];
              y_pixel_d     = y_q[IMG_HB-1:0];
              zone_id_d     = ZB'(zrow_q) * NxZ + ZB'(zcol_q);
              color_d       = {r_q, byte_w};
              frame_start_d = (x_q == '0) && (y_q == '0);
              if (zx_q == ZwLast) begin
                zx_d = '0;
                if (zcol_q != ZcolLast) zcol_d = zcol_q + 1'b1;
              end else begin
                zx_d = zx_q + 1'b1;
              end
            end
            // Keeps counting past the line end so over-long lines are still caught
            if (x_q != '1) x_d = x_q + 1'b1;
          end
        end
      end

      default: state_d = StBlank;
    endcase
  end

  // State, counters, edge-detect history and registered outputs
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StBlank;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      phase_q       <= 1'b0;
      r_q           <= '0;
      x_q           <= '0;
      y_q           <= '0;
      zx_q          <= '0;
      zcol_q        <= '0;
      zy_q          <= '0;
      zrow_q        <= '0;
      pix_valid_q   <= 1'b0;
      x_pixel_q     <= '0;
      y_pixel_q     <= '0;
      zone_id_q     <= '0;
      color_q       <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_short_q <= 1'b0;
      line_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      vsync_q       <= vsync;
      href_q        <= href;
      phase_q       <= phase_d;
      r_q           <= r_d;
      x_q           <= x_d;
      y_q           <= y_d;
      zx_q          <= zx_d;
      zcol_q        <= zcol_d;
      zy_q          <= zy_d;
      zrow_q        <= zrow_d;
      pix_valid_q   <= pix_valid_d;
      x_pixel_q     <= x_pixel_d;
      y_pixel_q     <= y_pixel_d;
      zone_id_q     <= zone_id_d;
      color_q       <= color_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      frame_short_q <= frame_short_d;
      line_err_q    <= line_err_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign x_pixel     = x_pixel_q;
  assign y_pixel     = y_pixel_q;
  assign zone_id     = zone_id_q;
  assign pixel_COLOR = color_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign frame_short = frame_short_q;
  assign line_err    = line_err_q;

endmodule

// File: tb/tb_hand_zone_pixel_streamer.sv
// Directed self-checking bench for hand_zone_pixel_streamer on a 16x12 image, 4x3 zones.
module tb_hand_zone_pixel_streamer;

  localparam int unsigned W  = 16;
  localparam int unsigned H  = 12;
  localparam int unsigned NX = 4;
  localparam int unsigned NY = 3;

  logic       pclk  = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b1;
  logic       href  = 1'b0;
  logic [7:0] cam_d = 8'h00;

  logic        pix_valid;
  logic [3:0]  x_pixel;
  logic [3:0]  y_pixel;
  logic [3:0]  zone_id;
  logic [11:0] pixel_COLOR;
  logic        frame_start, frame_done, frame_short, line_err;

  int n_cmp = 0;
  int n_err = 0;
  int pv_cnt = 0, fs_cnt = 0, fd_cnt = 0, le_cnt = 0;

  hand_zone_pixel_streamer #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .NX        (NX),
    .NY        (NY)
  ) dut (
    .pclk       (pclk),
    .rst_n      (rst_n),
    .vsync      (vsync),
    .href       (href),
    .cam_d      (cam_d),
`ifdef HAND_TEST_PATTERN_EN
    .test_mode  (1'b0),
`endif
    .pix_valid  (pix_valid),
    .x_pixel    (x_pixel),
    .y_pixel    (y_pixel),
    .zone_id    (zone_id),
    .pixel_COLOR(pixel_COLOR),
    .frame_start(frame_start),
    .frame_done (frame_done),
    .frame_short(frame_short),
    .line_err   (line_err)
  );

  always #5 pclk = ~pclk;

  // Pulse counters sampled on the falling edge
  always @(negedge pclk) begin
    pv_cnt <= pv_cnt + int'(pix_valid);
    fs_cnt <= fs_cnt + int'(frame_start);
    fd_cnt <= fd_cnt + int'(frame_done);
    le_cnt <= le_cnt + int'(line_err);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  task automatic start_frame();
    href  = 1'b0;
    vsync = 1'b1;
    repeat (3) cyc();
    vsync = 1'b0;
    repeat (2) cyc();
  endtask

  task automatic send_pix(input logic [7:0] b0, input logic [7:0] b1);
    href  = 1'b1;
    cam_d = b0;
    cyc();
    cam_d = b1;
    cyc();
  endtask

  task automatic end_line();
    href  = 1'b0;
    cam_d = 8'h00;
    cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vsync = 1'b1;
    repeat (2) cyc();
    n_cmp++;
    if ({pix_valid, x_pixel, y_pixel, zone_id, pixel_COLOR, frame_start, frame_done,
         frame_short, line_err} !== 33'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got pv=%b x=%0d y=%0d z=%0d c=%h fs=%b fd=%b sh=%b le=%b want all 0",
               pix_valid, x_pixel, y_pixel, zone_id, pixel_COLOR, frame_start, frame_done,
               frame_short, line_err);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_full_frame();
    int pv0, fs0;
    logic [3:0] zexp;
    pv0 = pv_cnt;
    fs0 = fs_cnt;
    start_frame();
    for (int y = 0; y < int'(H); y++) begin
      for (int x = 0; x < int'(W); x++) begin
        send_pix(8'h0A, 8'h5C);
        zexp = 4'((y / 4) * 4 + x / 4);
        n_cmp++;
        if ({pix_valid, frame_start, pixel_COLOR, x_pixel, y_pixel, zone_id} !==
            {1'b1, (x == 0 && y == 0), 12'hA5C, 4'(x), 4'(y), zexp}) begin
          n_err++;
          $display("FAIL full_pixel(%0d,%0d): got pv=%b fs=%b c=%h x=%0d y=%0d z=%0d want z=%0d c=A5C",
                   x, y, pix_valid, frame_start, pixel_COLOR, x_pixel, y_pixel, zone_id, zexp);
        end
        if (x == 5 && y == 6) begin
          n_cmp++;
          if (zone_id !== 4'd5) begin
            n_err++;
            $display("FAIL zone_5_6: got %0d want 5", zone_id);
          end
        end
        if (x == 15 && y == 11) begin
          n_cmp++;
          if (zone_id !== 4'd11) begin
            n_err++;
            $display("FAIL zone_15_11: got %0d want 11", zone_id);
          end
        end
      end
      end_line();
      n_cmp++;
      if ({pix_valid, line_err, frame_done, frame_short} !== {1'b0, 1'b0, (y == 11), 1'b0}) begin
        n_err++;
        $display("FAIL full_line_end(%0d): got pv=%b le=%b fd=%b sh=%b want le=0 fd=%b sh=0",
                 y, pix_valid, line_err, frame_done, frame_short, (y == 11));
      end
    end
    cyc();
    n_cmp++;
    if (pv_cnt - pv0 != 192) begin
      n_err++;
      $display("FAIL full_pv_count: got %0d want 192", pv_cnt - pv0);
    end
    n_cmp++;
    if (fs_cnt - fs0 != 1) begin
      n_err++;
      $display("FAIL full_fs_count: got %0d want 1", fs_cnt - fs0);
    end
  endtask

  task automatic test_first_pixel();
    start_frame();
    href  = 1'b1;
    cam_d = 8'h03;
    cyc();
    n_cmp++;
    if (pix_valid !== 1'b0) begin
      n_err++;
      $display("FAIL first_half_pixel: got pv=%b want 0", pix_valid);
    end
    cam_d = 8'h7E;
    cyc();
    n_cmp++;
    if ({pix_valid, frame_start, pixel_COLOR, x_pixel, y_pixel} !==
        {1'b1, 1'b1, 12'h37E, 4'd0, 4'd0}) begin
      n_err++;
      $display("FAIL first_pixel: got pv=%b fs=%b c=%h x=%0d y=%0d want 1 1 37E 0 0",
               pix_valid, frame_start, pixel_COLOR, x_pixel, y_pixel);
    end
    end_line();
    n_cmp++;
    if ({line_err, frame_done} !== 2'b10) begin
      n_err++;
      $display("FAIL first_short_line: got le=%b fd=%b want le=1 fd=0", line_err, frame_done);
    end
    vsync = 1'b1;
    cyc();
    n_cmp++;
    if ({frame_done, frame_short} !== 2'b11) begin
      n_err++;
      $display("FAIL first_early_vsync: got fd=%b sh=%b want 1 1", frame_done, frame_short);
    end
  endtask

  task automatic test_odd_line();
    start_frame();
    for (int i = 0; i < 15; i++) send_pix(8'h01, 8'h22);
    href  = 1'b1;
    cam_d = 8'h03;
    cyc();
    end_line();
    n_cmp++;
    if (line_err !== 1'b1) begin
      n_err++;
      $display("FAIL odd_line_err: got %b want 1", line_err);
    end
    send_pix(8'h04, 8'h55);
    n_cmp++;
    if ({pix_valid, x_pixel, y_pixel, pixel_COLOR} !== {1'b1, 4'd0, 4'd1, 12'h455}) begin
      n_err++;
      $display("FAIL odd_next_line: got pv=%b x=%0d y=%0d c=%h want 1 0 1 455",
               pix_valid, x_pixel, y_pixel, pixel_COLOR);
    end
    for (int i = 1; i < int'(W); i++) send_pix(8'h04, 8'h55);
    end_line();
    n_cmp++;
    if (line_err !== 1'b0) begin
      n_err++;
      $display("FAIL odd_good_line_err: got %b want 0", line_err);
    end
    vsync = 1'b1;
    cyc();
  endtask

  task automatic test_long_line();
    int pv0;
    start_frame();
    pv0 = pv_cnt;
    for (int i = 0; i < 20; i++) begin
      send_pix(8'h0C, 8'hDE);
      if (i == 15) begin
        n_cmp++;
        if ({pix_valid, x_pixel, pixel_COLOR} !== {1'b1, 4'd15, 12'hCDE}) begin
          n_err++;
          $display("FAIL long_last_pixel: got pv=%b x=%0d c=%h want 1 15 CDE",
                   pix_valid, x_pixel, pixel_COLOR);
        end
      end
      if (i == 16) begin
        n_cmp++;
        if (pix_valid !== 1'b0) begin
          n_err++;
          $display("FAIL long_extra_pixel: got pv=%b want 0", pix_valid);
        end
      end
    end
    end_line();
    n_cmp++;
    if (line_err !== 1'b1) begin
      n_err++;
      $display("FAIL long_line_err: got %b want 1", line_err);
    end
    cyc();
    n_cmp++;
    if (pv_cnt - pv0 != 16) begin
      n_err++;
      $display("FAIL long_pv_count: got %0d want 16", pv_cnt - pv0);
    end
    vsync = 1'b1;
    cyc();
  endtask

  task automatic test_short_frame();
    int fd0;
    start_frame();
    for (int l = 0; l < 5; l++) begin
      for (int i = 0; i < int'(W); i++) send_pix(8'h0A, 8'h5C);
      end_line();
      n_cmp++;
      if ({line_err, frame_done} !== 2'b00) begin
        n_err++;
        $display("FAIL short_line(%0d): got le=%b fd=%b want 0 0", l, line_err, frame_done);
      end
    end
    fd0 = fd_cnt;
    vsync = 1'b1;
    cyc();
    n_cmp++;
    if ({frame_done, frame_short} !== 2'b11) begin
      n_err++;
      $display("FAIL short_done: got fd=%b sh=%b want 1 1", frame_done, frame_short);
    end
    cyc();
    n_cmp++;
    if (fd_cnt - fd0 != 1) begin
      n_err++;
      $display("FAIL short_done_count: got %0d want 1", fd_cnt - fd0);
    end
    start_frame();
    send_pix(8'h0A, 8'h5C);
    n_cmp++;
    if ({pix_valid, frame_start, x_pixel, y_pixel} !== {1'b1, 1'b1, 4'd0, 4'd0}) begin
      n_err++;
      $display("FAIL restart_pixel: got pv=%b fs=%b x=%0d y=%0d want 1 1 0 0",
               pix_valid, frame_start, x_pixel, y_pixel);
    end
    for (int i = 1; i < int'(W); i++) send_pix(8'h0A, 8'h5C);
    // href fall and vsync rise on the same cycle
    fd0   = fd_cnt;
    href  = 1'b0;
    vsync = 1'b1;
    cyc();
    n_cmp++;
    if ({line_err, frame_done, frame_short} !== 3'b011) begin
      n_err++;
      $display("FAIL simul_fall_rise: got le=%b fd=%b sh=%b want 0 1 1",
               line_err, frame_done, frame_short);
    end
    repeat (2) cyc();
    n_cmp++;
    if (fd_cnt - fd0 != 1) begin
      n_err++;
      $display("FAIL simul_done_count: got %0d want 1", fd_cnt - fd0);
    end
  endtask

  task automatic test_reset_midline();
    int pv0, le0;
    start_frame();
    send_pix(8'h0A, 8'h5C);
    send_pix(8'h0A, 8'h5C);
    href  = 1'b1;
    cam_d = 8'h0A;
    cyc();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({pix_valid, x_pixel, y_pixel, zone_id, pixel_COLOR, frame_start, frame_done,
         frame_short, line_err} !== 33'd0) begin
      n_err++;
      $display("FAIL midline_reset_outputs: got pv=%b x=%0d c=%h want all 0",
               pix_valid, x_pixel, pixel_COLOR);
    end
    cam_d = 8'h5C;
    repeat (2) cyc();
    rst_n = 1'b1;
    pv0   = pv_cnt;
    le0   = le_cnt;
    for (int i = 0; i < 3; i++) send_pix(8'h0A, 8'h5C);
    end_line();
    repeat (3) cyc();
    n_cmp++;
    if ((pv_cnt - pv0 != 0) || (le_cnt - le0 != 0)) begin
      n_err++;
      $display("FAIL post_reset_quiet: got pv=%0d le=%0d want 0 0", pv_cnt - pv0, le_cnt - le0);
    end
    start_frame();
    send_pix(8'h0A, 8'h5C);
    n_cmp++;
    if ({pix_valid, frame_start, x_pixel, y_pixel, pixel_COLOR} !==
        {1'b1, 1'b1, 4'd0, 4'd0, 12'hA5C}) begin
      n_err++;
      $display("FAIL post_reset_frame: got pv=%b fs=%b x=%0d y=%0d c=%h want 1 1 0 0 A5C",
               pix_valid, frame_start, x_pixel, y_pixel, pixel_COLOR);
    end
    href  = 1'b0;
    vsync = 1'b1;
    cyc();
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_first_pixel();
    test_odd_line();
    test_long_line();
    test_short_frame();
    test_reset_midline();
    repeat (2) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
